ubs2bin_window: RTL
===================

# ubs2bin_window

Windowed unary-bitstream-to-binary converter. It sits directly downstream of the JK-flip-flop unary divide/square-root stage and counts the ones in that stage's output bitstream over a fixed window of 2^WIDTH valid samples. It then presents the count as a binary value, unipolar or bipolar, through a valid/ready handshake. It is the standard readout point for unary-compute results in software-checked benches and in binary-domain consumers.

## Interface
Parameters:
- WIDTH, default 8: log2 of window length; window = 2^WIDTH valid samples.
- BIPOLAR, default 0: 0 = unipolar output; 1 = bipolar (two's-complement) output.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in  input  1  bitstream sample from the upstream unary stage.
- in_valid  input  1  `in` is a countable sample this cycle.
- start  input  1  request to begin a new window.
- busy  output  1  high in RUN.
- out_data  output  WIDTH+1  window result; format set by BIPOLAR.
- out_valid  output  1  `out_data` holds a completed result.
- out_ready  input  1  consumer accepts the result.

## Operation
FSM states are IDLE, RUN and HOLD. Reset state is IDLE.
- IDLE:
  - start=1 -> RUN; sample counter and ones counter clear to 0.
  - Samples arriving in IDLE are discarded.
- RUN:
  - Each cycle with in_valid=1: sample counter +1; ones counter +in.
  - The final accepted sample is the one where sample counter == 2^WIDTH-1 with in_valid=1. That same cycle, register the result and go to HOLD.
  - start is ignored in RUN.
- HOLD:
  - out_valid=1 and out_data stays stable until out_ready=1.
  - On the handshake cycle (out_valid & out_ready): if start=1, go to RUN with counters cleared (back-to-back windows). Otherwise go to IDLE.
  - start without out_ready is ignored. Samples in HOLD are discarded.
- Arithmetic:
  - Sample counter is WIDTH bits and wraps only via state exit.
  - Ones counter is WIDTH+1 bits, range 0..2^WIDTH, and never saturates or overflows by construction.
- Result format:
  - Unipolar: out_data = ones, unsigned, 0..2^WIDTH.
  - Bipolar: out_data = ones − 2^(WIDTH−1), two's complement, range −2^(WIDTH−1)..+2^(WIDTH−1). This equals (2·ones − 2^WIDTH)/2, i.e. the bipolar value scaled by 2^(WIDTH−1).
- out_data updates only on entry to HOLD. It retains the last result in IDLE and RUN, and is qualified solely by out_valid.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, both counters 0, state IDLE.
- Reset mid-operation discards the partial window immediately. There is no output pulse.
- start accepted at edge t: the first countable sample is at edge t+1.
- Latency: out_valid rises at the edge following the final accepted sample.
  - With continuous in_valid, a window occupies 2^WIDTH cycles in RUN.
  - out_valid is high from cycle 2^WIDTH+1 after start.
- Back-to-back throughput: one result per 2^WIDTH+1 cycles, due to the handshake cycle.
- Handshake: out_valid never drops without out_ready. out_data is constant while out_valid=1.
- busy is registered and high exactly while the state is RUN.
- Simultaneous events: in HOLD, out_ready and start in the same cycle takes the back-to-back path to RUN.

## Structure
- Shared package ubs_pkg holds:
  - the state typedef (enum of IDLE, RUN, HOLD) for reuse by other unary readout blocks;
  - a localparam helper for the bipolar offset 2^(WIDTH−1).
- One sub-module is natural: ubs_ones_cnt. It holds the sample counter and ones counter with clear/enable inputs and a `last` flag output.
- The top level holds the FSM, the result register and the format conversion.

## Test plan
All scenarios use WIDTH=4 (16-sample window).
1. All ones, continuous in_valid, BIPOLAR=0 -> out_data=16 and out_valid rises 17 cycles after start. With BIPOLAR=1 -> out_data=+8.
2. All zeros, BIPOLAR=1 -> out_data=−8 (5'b11000). Alternating 1010… -> 8 unipolar, 0 bipolar.
3. in_valid low on every other cycle with in=1 always -> window takes 32 cycles and result = 16. Ones presented with in_valid=0 are not counted.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and out_data stay stable. Then out_ready=1 together with start=1 -> next window starts with no IDLE cycle.
5. Reset mid-window: assert rst_n=0 after 7 samples -> all outputs 0 asynchronously, and no out_valid after release. A fresh start with 16 ones then gives 16.
6. Upstream chain: drive from the JK divide/sqrt stage with input probability 0.25 (WIDTH=8, 256 samples) -> unipolar count within ±16 of 128, i.e. sqrt(0.25)=0.5. Also, start asserted during RUN -> no effect on the count.

Source files
------------

// File: rtl/ubs_pkg.sv
// ---------------------------------------------------------------------------
// ubs_pkg
// Shared definitions for the unary-bitstream readout blocks.
//   ubs_state_t : readout FSM state encoding (IDLE / RUN / HOLD)
//   bip_offset  : bipolar offset 2^(width-1) used to centre a count on zero
// ---------------------------------------------------------------------------
package ubs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ubs_state_t;

  // Half of a 2^width window: the count that maps to bipolar zero.
  function automatic int unsigned bip_offset(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/ubs_ones_cnt.sv
// ---------------------------------------------------------------------------
// ubs_ones_cnt
// Sample counter (WIDTH bits) and ones counter (WIDTH+1 bits) for one window.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear of both counters (priority over i_en)
//   i_en       : count this sample
//   i_bit      : sample value added to the ones counter when enabled
//   o_ones     : current ones count (0 .. 2^WIDTH)
//   o_last     : sample counter is at 2^WIDTH-1, next enabled sample is final
// ---------------------------------------------------------------------------
module ubs_ones_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [WIDTH:0]   o_ones,
  output logic             o_last
);

  logic [WIDTH-1:0] r_samp;
  logic [WIDTH:0]   r_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp <= '0;
      r_ones <= '0;
    end else if (i_clr) begin
      r_samp <= '0;
      r_ones <= '0;
    end else if (i_en) begin
      r_samp <= r_samp + 1'b1;
      r_ones <= r_ones + {{WIDTH{1'b0}}, i_bit};
    end
  end

  assign o_ones = r_ones;
  assign o_last = &r_samp;

endmodule

// File: rtl/ubs2bin_window.sv
// ---------------------------------------------------------------------------
// ubs2bin_window
// Counts ones in a unary bitstream over 2^WIDTH valid samples and presents the
// count (unipolar or bipolar two's complement) through a valid/ready handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : bitstream sample
//   in_valid   : sample is countable this cycle
//   start      : begin a new window (IDLE, or HOLD together with out_ready)
//   busy       : high while a window is being collected (RUN)
//   out_data   : WIDTH+1 bit result, stable while out_valid is high
//   out_valid  : result available
//   out_ready  : consumer takes the result
// ---------------------------------------------------------------------------
module ubs2bin_window
  import ubs_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BIPOLAR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [WIDTH:0] BIP_OFS = (WIDTH+1)'(bip_offset(WIDTH));

  ubs_state_t     r_state;
  ubs_state_t     w_state_next;
  logic           r_busy;
  logic           r_out_valid;
  logic [WIDTH:0] r_out_data;

  logic           w_clr;
  logic           w_en;
  logic           w_final;
  logic           w_last;
  logic [WIDTH:0] w_ones;
  logic [WIDTH:0] w_ones_final;
  logic [WIDTH:0] w_result;

  ubs_ones_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_bit  (in),
    .o_ones (w_ones),
    .o_last (w_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start) w_state_next = RUN;
      RUN:  if (w_final) w_state_next = HOLD;
      HOLD: if (out_ready) w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Control outputs of the FSM
  always_comb begin
    w_clr   = 1'b0;
    w_en    = 1'b0;
    w_final = 1'b0;
    case (r_state)
      IDLE: w_clr = start;
      RUN: begin
        w_en    = in_valid;
        w_final = in_valid & w_last;
      end
      HOLD: w_clr = out_ready & start;
      default: ;
    endcase
  end

  // The final sample is still in flight to the counter, so fold it in here.
  assign w_ones_final = w_ones + {{WIDTH{1'b0}}, in};

  // Bipolar: subtracting half the window in WIDTH+1 bits yields the
  // two's-complement value directly (range -2^(W-1) .. +2^(W-1) fits).
  generate
    if (BIPOLAR != 0) begin : g_bip
      assign w_result = w_ones_final - BIP_OFS;
    end else begin : g_uni
      assign w_result = w_ones_final;
    end
  endgenerate

  // Registered outputs, derived from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_busy      <= (w_state_next == RUN);
      r_out_valid <= (w_state_next == HOLD);
      if (w_final) r_out_data <= w_result;
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
